vga_display_core: RTL

//  Parametrised VGA timing generator plus registered pixel output stage; next generation of the VGA top.

---
 rtl/vga_display_core_if.sv | 30 +++
 rtl/vga_display_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_display_core_if.sv
// Pixel-side bundle of the VGA core: graphics-source request/response plus the
// registered pins driven towards the DAC.
interface vga_display_core_if #(
    parameter int COLOR_BITS = 1
);
    logic [1:0]              mode;
    logic [3*COLOR_BITS-1:0] rgb_in;
    logic [9:0]              pixel_x;
    logic [9:0]              pixel_y;
    logic                    p_tick;
    logic                    video_on;
    logic                    frame_start;
    logic                    VGA_HS;
    logic                    VGA_VS;
    logic [7:0]              VGA_R;
    logic [7:0]              VGA_G;
    logic [7:0]              VGA_B;

    modport master (
        input  mode, rgb_in,
        output pixel_x, pixel_y, p_tick, video_on, frame_start,
        output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output mode, rgb_in,
        input  pixel_x, pixel_y, p_tick, video_on, frame_start,
        input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_display_core.sv
// Parametrised VGA timing generator with a single registered output stage so
// that syncs, video_on and colour always leave on the same pixel tick.
module vga_display_core #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int COLOR_BITS = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 KEY,
    vga_display_core_if.master   vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (CLK_DIV < 1 || H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            H_TOTAL > 1024 || V_TOTAL > 1024 || COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_bad_cfg
            $error("vga_display_core: illegal timing or colour configuration");
        end
    endgenerate

    localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_W    = 10'(H_ACTIVE / 8);
    localparam logic       SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

    // MSB-first replication: a narrow channel value fills 8 bits without bias.
    function automatic logic [7:0] expand_channel(input logic [COLOR_BITS-1:0] c);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
        end
        return e;
    endfunction

    logic [DIV_W-1:0] div_r;
    logic             run_r;
    logic [9:0]       h_r;
    logic [9:0]       v_r;
    logic [1:0]       active_mode_r;
    logic             video_on_r;
    logic             hs_r;
    logic             vs_r;
    logic [7:0]       red_r;
    logic [7:0]       green_r;
    logic [7:0]       blue_r;

    logic             p_tick_s;
    logic             frame_tick_s;
    logic [1:0]       eff_mode_s;
    logic             vis_s;
    logic             hs_act_s;
    logic             vs_act_s;
    logic [2:0]       bar_idx_s;
    logic             checker_s;
    logic [7:0]       sel_r_s;
    logic [7:0]       sel_g_s;
    logic [7:0]       sel_b_s;

    // run_r keeps p_tick low during reset even when CLK_DIV is 1
    assign p_tick_s     = run_r && (div_r == DIV_LAST);
    assign frame_tick_s = p_tick_s && (h_r == 10'd0) && (v_r == 10'd0);
    assign eff_mode_s   = frame_tick_s ? vga.mode : active_mode_r;
    assign vis_s        = (h_r < H_VIS) && (v_r < V_VIS);
    assign hs_act_s     = (h_r >= HS_BEGIN) && (h_r < HS_END);
    assign vs_act_s     = (v_r >= VS_BEGIN) && (v_r < VS_END);
    assign bar_idx_s    = 3'(h_r / BAR_W);
    assign checker_s    = h_r[5] ^ v_r[5];

    // Pixel-rate divider
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            div_r <= '0;
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + 1'b1;
            end
        end
    end

    // Horizontal and vertical position counters
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            h_r <= 10'd0;
            v_r <= 10'd0;
        end else if (p_tick_s) begin
            if (h_r == H_LAST) begin
                h_r <= 10'd0;
                if (v_r == V_LAST) begin
                    v_r <= 10'd0;
                end else begin
                    v_r <= v_r + 10'd1;
                end
            end else begin
                h_r <= h_r + 10'd1;
            end
        end
    end

    // Colour source selection for the current counter position
    always_comb begin
        sel_r_s = 8'h00;
        sel_g_s = 8'h00;
        sel_b_s = 8'h00;
        case (eff_mode_s)
            2'd0: begin
                sel_r_s = expand_channel(vga.rgb_in[3*COLOR_BITS-1 -: COLOR_BITS]);
                sel_g_s = expand_channel(vga.rgb_in[2*COLOR_BITS-1 -: COLOR_BITS]);
                sel_b_s = expand_channel(vga.rgb_in[COLOR_BITS-1 -: COLOR_BITS]);
            end
            2'd1: begin
                sel_r_s = {8{bar_idx_s[2]}};
                sel_g_s = {8{bar_idx_s[1]}};
                sel_b_s = {8{bar_idx_s[0]}};
            end
            2'd2: begin
                sel_r_s = {8{checker_s}};
                sel_g_s = {8{checker_s}};
                sel_b_s = {8{checker_s}};
            end
            2'd3: begin
                sel_r_s = 8'h00;
                sel_g_s = 8'h00;
                sel_b_s = 8'h00;
            end
            default: begin
                sel_r_s = 8'h00;
                sel_g_s = 8'h00;
                sel_b_s = 8'h00;
            end
        endcase
    end

    // Output stage: syncs, blanking and colour share one register per tick
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            active_mode_r <= 2'd0;
            video_on_r    <= 1'b0;
            hs_r          <= SYNC_IDLE;
            vs_r          <= SYNC_IDLE;
            red_r         <= 8'h00;
            green_r       <= 8'h00;
            blue_r        <= 8'h00;
        end else if (p_tick_s) begin
            if (frame_tick_s) begin
                active_mode_r <= vga.mode;
            end
            video_on_r <= vis_s;
            hs_r       <= hs_act_s ^ SYNC_IDLE;
            vs_r       <= vs_act_s ^ SYNC_IDLE;
            red_r      <= vis_s ? sel_r_s : 8'h00;
            green_r    <= vis_s ? sel_g_s : 8'h00;
            blue_r     <= vis_s ? sel_b_s : 8'h00;
        end
    end

    assign vga.pixel_x     = h_r;
    assign vga.pixel_y     = v_r;
    assign vga.p_tick      = p_tick_s;
    assign vga.frame_start = frame_tick_s;
    assign vga.video_on    = video_on_r;
    assign vga.VGA_HS      = hs_r;
    assign vga.VGA_VS      = vs_r;
    assign vga.VGA_R       = red_r;
    assign vga.VGA_G       = green_r;
    assign vga.VGA_B       = blue_r;

endmodule
